// File: rtl/fp_addsub_pipe.sv
// Multi-cycle floating-point adder/subtractor with parametrised exponent and
// mantissa widths. One operation is in flight at a time. It walks through
// IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both high. An output transfer happens on a rising edge where
// out_valid and out_ready are both high. While out_valid is high and
// out_ready is low, result and flags are held stable.
// Subnormal operands are flushed to zero. The result is rounded to nearest
// even, and NaN results are always the canonical quiet NaN.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 invalid,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 inexact
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;          // hidden, frac, guard, round, sticky
    localparam int XW  = EXP_W + 2;          // signed internal exponent
    localparam int LZW = $clog2(SW);
    localparam logic [EXP_W-1:0] EMAX = '1;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state, state_nxt;

    // captured operands and per-stage registers
    logic [W-1:0]   a_q, b_q;
    logic           op_q;
    logic           sp_r, sp_inv_r, sgn_r, sub_r, zero_r;
    logic [W-1:0]   sp_res_r;
    logic [XW-1:0]  ex_r;
    logic [SW-1:0]  big_r, sml_r, nrm_r;
    logic [SW:0]    sum_r;

    // align-stage combinational signals
    logic           sa, sb, s_big, s_sml;
    logic [EXP_W-1:0] ea, eb, e_big, e_sml, diff, sh;
    logic [MAN_W-1:0] fa, fb, f_big, f_sml;
    logic           a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
    logic [SW-1:0]  sig_sml, sml_c;
    logic           sp_c, sp_inv_c;
    logic [W-1:0]   sp_res_c;

    // norm/round-stage combinational signals
    logic [LZW-1:0] lz;
    logic [SW-1:0]  nrm_c;
    logic [XW-1:0]  ex_nc, ex_f;
    logic [MAN_W+1:0] mant;
    logic [MAN_W-1:0] frac_f;
    logic           inc, rnd_inx;
    logic [W-1:0]   res_c;
    logic           inv_c, ovf_c, unf_c, inx_c;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    // state register; reset drops any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state: one cycle per middle stage, DONE waits for the consumer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_nxt = ALIGN;
            ALIGN:   state_nxt = ADD;
            ADD:     state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // decode, special-case detection and alignment of the smaller operand
    always_comb begin
        sa = a_q[W-1];
        ea = a_q[W-2:MAN_W];
        fa = a_q[MAN_W-1:0];
        sb = b_q[W-1] ^ op_q;
        eb = b_q[W-2:MAN_W];
        fb = b_q[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EMAX) && (fa == '0);
        b_inf  = (eb == EMAX) && (fb == '0);
        a_nan  = (ea == EMAX) && (fa != '0);
        b_nan  = (eb == EMAX) && (fb != '0);
        a_big  = {ea, fa} >= {eb, fb};
        s_big  = a_big ? sa : sb;
        s_sml  = a_big ? sb : sa;
        e_big  = a_big ? ea : eb;
        e_sml  = a_big ? eb : ea;
        f_big  = a_big ? fa : fb;
        f_sml  = a_big ? fb : fa;
        diff   = e_big - e_sml;
        sh     = (32'(diff) > MAN_W + 3) ? EXP_W'(MAN_W + 3) : diff;
        sig_sml = {1'b1, f_sml, 3'b000};
        sml_c   = sig_sml >> sh;
        sml_c[0] = sml_c[0] | (|(sig_sml & ~({SW{1'b1}} << sh)));

        sp_c     = 1'b1;
        sp_inv_c = 1'b0;
        sp_res_c = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            sp_res_c = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
            sp_inv_c = 1'b1;
        end else if (a_inf) begin
            sp_res_c = {sa, a_q[W-2:0]};
        end else if (b_inf) begin
            sp_res_c = {sb, b_q[W-2:0]};
        end else if (a_zero && b_zero) begin
            sp_res_c = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            sp_res_c = {sb, b_q[W-2:0]};
        end else if (b_zero) begin
            sp_res_c = {sa, a_q[W-2:0]};
        end else begin
            sp_c = 1'b0;
        end
    end

    // normalisation: carry shifts right, otherwise shift out leading zeros
    always_comb begin
        lz = '0;
        for (int i = 0; i < SW; i++) begin
            if (sum_r[i]) lz = LZW'(SW - 1 - i);
        end
        if (sum_r[SW]) begin
            nrm_c = {sum_r[SW:2], sum_r[1] | sum_r[0]};
            ex_nc = ex_r + XW'(1);
        end else begin
            nrm_c = sum_r[SW-1:0] << lz;
            ex_nc = ex_r - XW'(lz);
        end
    end

    // round to nearest even, then range check and special override
    always_comb begin
        inc     = nrm_r[2] & (nrm_r[1] | nrm_r[0] | nrm_r[3]);
        rnd_inx = nrm_r[2] | nrm_r[1] | nrm_r[0];
        mant    = {1'b0, nrm_r[SW-1:3]} + (MAN_W+2)'(inc);
        if (mant[MAN_W+1]) begin
            ex_f   = ex_r + XW'(1);
            frac_f = mant[MAN_W:1];
        end else begin
            ex_f   = ex_r;
            frac_f = mant[MAN_W-1:0];
        end
        res_c = '0;
        inv_c = 1'b0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        inx_c = 1'b0;
        if (sp_r) begin
            res_c = sp_res_r;
            inv_c = sp_inv_r;
        end else if (zero_r) begin
            res_c = '0;
        end else if (!ex_f[XW-1] && (ex_f >= {2'b00, EMAX})) begin
            res_c = {sgn_r, EMAX, {MAN_W{1'b0}}};
            ovf_c = 1'b1;
            inx_c = 1'b1;
        end else if (ex_f[XW-1] || (ex_f == '0)) begin
            res_c = {sgn_r, {(W-1){1'b0}}};
            unf_c = 1'b1;
            inx_c = 1'b1;
        end else begin
            res_c = {sgn_r, ex_f[EXP_W-1:0], frac_f};
            inx_c = rnd_inx;
        end
    end

    // datapath registers, each loaded in the state that produces them
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_q  <= a;
                    b_q  <= b;
                    op_q <= op;
                end
            end
            ALIGN: begin
                sp_r     <= sp_c;
                sp_res_r <= sp_res_c;
                sp_inv_r <= sp_inv_c;
                sgn_r    <= s_big;
                ex_r     <= {2'b00, e_big};
                big_r    <= {1'b1, f_big, 3'b000};
                sml_r    <= sml_c;
                sub_r    <= s_big ^ s_sml;
            end
            ADD: begin
                sum_r <= sub_r ? ({1'b0, big_r} - {1'b0, sml_r})
                               : ({1'b0, big_r} + {1'b0, sml_r});
            end
            NORM: begin
                nrm_r  <= nrm_c;
                ex_r   <= ex_nc;
                zero_r <= (sum_r == '0);
            end
            default: ;
        endcase
    end

    // result and flags: cleared by reset, flags cleared on accept, loaded leaving ROUND
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            invalid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else if (in_valid && in_ready) begin
            invalid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else if (state == ROUND) begin
            result    <= res_c;
            invalid   <= inv_c;
            overflow  <= ovf_c;
            underflow <= unf_c;
            inexact   <= inx_c;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: single-precision and half-precision instances,
// directed vectors with known answers, handshake/reset scenarios and random
// operands scored against an exact-integer reference model.
module tb_fp_addsub_pipe;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- DUT signals ----------------
    logic        iv_s, ir_s, ov_s, op_s, inv_s, ovf_s, unf_s, inx_s;
    logic [31:0] a_s, b_s, r_s;
    logic        iv_h, ir_h, ov_h, op_h, inv_h, ovf_h, unf_h, inx_h;
    logic [15:0] a_h, b_h, r_h;
    logic        ordy;
    logic        sel;   // 0: single instance, 1: half instance

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut_s (
        .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir_s), .a(a_s), .b(b_s),
        .op(op_s), .out_valid(ov_s), .out_ready(ordy), .result(r_s),
        .invalid(inv_s), .overflow(ovf_s), .underflow(unf_s), .inexact(inx_s));

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(iv_h), .in_ready(ir_h), .a(a_h), .b(b_h),
        .op(op_h), .out_valid(ov_h), .out_ready(ordy), .result(r_h),
        .invalid(inv_h), .overflow(ovf_h), .underflow(unf_h), .inexact(inx_h));

    logic        obs_valid, obs_ready;
    logic [35:0] obs_out;   // {invalid, overflow, underflow, inexact, result}
    assign obs_valid = sel ? ov_h : ov_s;
    assign obs_ready = sel ? ir_h : ir_s;
    assign obs_out   = sel ? {inv_h, ovf_h, unf_h, inx_h, 16'h0, r_h}
                           : {inv_s, ovf_s, unf_s, inx_s, r_s};

    // ---------------- scoreboard ----------------
    logic [35:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] pack(input int ew, input int mw, input logic s,
                                         input logic [31:0] e, input logic [31:0] f);
        return (32'(s) << (ew + mw)) | (e << mw) | f;
    endfunction

    // Exact sum on wide integers; a far-smaller operand is replaced by one
    // tiny unit, which rounds identically since it cannot cross a midpoint.
    function automatic logic [35:0] ref_model(input int ew, input int mw, input logic [31:0] av,
                                              input logic [31:0] bv, input logic opv);
        logic [31:0]  emax, fmask, ea, eb, fa, fb, qnan;
        logic         sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s_big, s_sml, inx;
        logic [127:0] m_big, m_sml, i_big, i_sml, mag, q, rem, half;
        int           e_big, e_sml, diff, dd, p, e, sh;
        emax  = (32'd1 << ew) - 32'd1;
        fmask = (32'd1 << mw) - 32'd1;
        ea = (av >> mw) & emax;  fa = av & fmask;  sa = av[ew+mw];
        eb = (bv >> mw) & emax;  fb = bv & fmask;  sb = bv[ew+mw] ^ opv;
        a_nan = (ea == emax) && (fa != 0);  a_inf = (ea == emax) && (fa == 0);  a_zero = (ea == 0);
        b_nan = (eb == emax) && (fb != 0);  b_inf = (eb == emax) && (fb == 0);  b_zero = (eb == 0);
        qnan = (emax << mw) | (32'd1 << (mw - 1));
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) return {4'b1000, qnan};
        if (a_inf) return {4'b0000, pack(ew, mw, sa, ea, fa)};
        if (b_inf) return {4'b0000, pack(ew, mw, sb, eb, fb)};
        if (a_zero && b_zero) return {4'b0000, pack(ew, mw, sa & sb, 0, 0)};
        if (a_zero) return {4'b0000, pack(ew, mw, sb, eb, fb)};
        if (b_zero) return {4'b0000, pack(ew, mw, sa, ea, fa)};
        if ((ea > eb) || ((ea == eb) && (fa >= fb))) begin
            e_big = int'(ea); e_sml = int'(eb); s_big = sa; s_sml = sb;
            m_big = 128'(fa) | (128'd1 << mw); m_sml = 128'(fb) | (128'd1 << mw);
        end else begin
            e_big = int'(eb); e_sml = int'(ea); s_big = sb; s_sml = sa;
            m_big = 128'(fb) | (128'd1 << mw); m_sml = 128'(fa) | (128'd1 << mw);
        end
        dd    = mw + 8;
        diff  = e_big - e_sml;
        i_big = m_big << dd;
        i_sml = (diff <= dd) ? (m_sml << (dd - diff)) : 128'd1;
        mag   = (s_big == s_sml) ? (i_big + i_sml) : (i_big - i_sml);
        if (mag == 0) return 36'd0;
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        e = e_big + p - (mw + dd);
        if (p > mw) begin
            sh   = p - mw;
            q    = mag >> sh;
            rem  = mag & ((128'd1 << sh) - 128'd1);
            half = 128'd1 << (sh - 1);
        end else begin
            q = mag << (mw - p); rem = 0; half = 0;
        end
        inx = (rem != 0);
        if ((rem > half) || ((rem == half) && (rem != 0) && q[0])) q = q + 1;
        if ((q >> (mw + 1)) != 0) begin q = q >> 1; e = e + 1; end
        if (e >= int'(emax)) return {4'b0101, pack(ew, mw, s_big, emax, 0)};
        if (e <= 0) return {4'b0011, pack(ew, mw, s_big, 0, 0)};
        return {3'b000, inx, pack(ew, mw, s_big, 32'(e), q[31:0] & fmask)};
    endfunction

    function automatic logic [35:0] model(input logic [31:0] av, input logic [31:0] bv, input logic opv);
        return sel ? ref_model(5, 10, av, bv, opv) : ref_model(8, 23, av, bv, opv);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!obs_ready && n < 50) begin @(negedge clk); n++; end
        check("in_ready_wait", {35'd0, obs_ready}, 36'd1);
    endtask

    // present one operation at a negedge; returns #1 after the accepting edge
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                        input logic [35:0] expv);
        if (sel) begin a_h = av[15:0]; b_h = bv[15:0]; op_h = opv; iv_h = 1'b1; end
        else     begin a_s = av;       b_s = bv;       op_s = opv; iv_s = 1'b1; end
        exp_q.push_back(expv);
        @(posedge clk); #1;
        iv_s = 1'b0; iv_h = 1'b0;
    endtask

    task automatic collect(input string tag);
        int lat = 0;
        logic [35:0] expv;
        while (!obs_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check({tag, "_latency"}, 36'(lat), 36'd4);
        expv = exp_q.pop_front();
        check(tag, obs_out, expv);
    endtask

    task automatic op_exp(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic opv, input logic [35:0] expv);
        wait_idle();
        send(av, bv, opv, expv);
        collect(tag);
    endtask

    task automatic op_model(input string tag, input logic [31:0] av, input logic [31:0] bv,
                            input logic opv);
        op_exp(tag, av, bv, opv, model(av, bv, opv));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [35:0] first_exp;
        logic [31:0] ra, rb;
        int          seen;
        rst = 1'b1; sel = 1'b0; ordy = 1'b1;
        iv_s = 1'b0; a_s = '0; b_s = '0; op_s = 1'b0;
        iv_h = 1'b0; a_h = '0; b_h = '0; op_h = 1'b0;

        // reset state
        #1;
        check("rst_outputs_s", obs_out, 36'd0);
        check("rst_out_valid_s", {35'd0, obs_valid}, 36'd0);
        check("rst_in_ready_s", {35'd0, obs_ready}, 36'd0);
        sel = 1'b1; #1;
        check("rst_outputs_h", obs_out, 36'd0);
        sel = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        check("post_rst_in_ready", {35'd0, obs_ready}, 36'd1);

        // directed single-precision vectors
        op_exp("sub_3_minus_1", 32'h40400000, 32'h3F800000, 1'b1, {4'b0000, 32'h40000000});
        op_exp("rne_tie_odd",   32'h3F800001, 32'h33800000, 1'b0, {4'b0001, 32'h3F800002});
        op_exp("rne_tie_even",  32'h3F800000, 32'h33800000, 1'b0, {4'b0001, 32'h3F800000});
        op_exp("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, {4'b1000, 32'h7FC00000});
        op_exp("nan_plus_one",  32'h7FA00000, 32'h3F800000, 1'b0, {4'b1000, 32'h7FC00000});
        op_exp("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, {4'b0000, 32'h7F800000});
        op_exp("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {4'b0101, 32'h7F800000});
        op_exp("cancel_zero",   32'h3F800000, 32'h3F800000, 1'b1, {4'b0000, 32'h00000000});
        op_exp("neg_zero_sum",  32'h80000000, 32'h80000000, 1'b0, {4'b0000, 32'h80000000});
        op_exp("zero_minus_b",  32'h00000000, 32'h40400000, 1'b1, {4'b0000, 32'hC0400000});

        // handshake: hold out_ready low in DONE, second request must wait
        wait_idle();
        ordy = 1'b0;
        first_exp = model(32'h40400000, 32'h3F800000, 1'b0);
        send(32'h40400000, 32'h3F800000, 1'b0, first_exp);
        collect("hs_first");
        a_s = 32'h3F800000; b_s = 32'h40000000; op_s = 1'b0; iv_s = 1'b1;
        exp_q.push_back(model(32'h3F800000, 32'h40000000, 1'b0));
        repeat (3) begin
            @(posedge clk); #1;
            check("hs_hold_valid", {35'd0, obs_valid}, 36'd1);
            check("hs_hold_data", obs_out, first_exp);
            check("hs_hold_in_ready", {35'd0, obs_ready}, 36'd0);
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        check("hs_idle_valid", {35'd0, obs_valid}, 36'd0);
        check("hs_idle_in_ready", {35'd0, obs_ready}, 36'd1);
        @(posedge clk); #1;
        iv_s = 1'b0;
        check("hs_second_accepted", {35'd0, obs_ready}, 36'd0);
        collect("hs_second");

        // asynchronous reset while in ROUND
        wait_idle();
        a_s = 32'h40A00000; b_s = 32'h3F800000; op_s = 1'b0; iv_s = 1'b1;
        @(posedge clk); #1;
        iv_s = 1'b0;
        repeat (3) @(posedge clk);
        #3; rst = 1'b1; #1;
        check("arst_outputs", obs_out, 36'd0);
        check("arst_out_valid", {35'd0, obs_valid}, 36'd0);
        check("arst_in_ready", {35'd0, obs_ready}, 36'd0);
        @(negedge clk); rst = 1'b0; #1;
        check("arst_release_ready", {35'd0, obs_ready}, 36'd1);
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (obs_valid) seen++; end
        check("arst_no_stale_valid", 36'(seen), 36'd0);

        // random single precision
        repeat (60) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = {1'($urandom_range(0, 1)), ra[30:0] ^ 31'($urandom_range(0, 15))};
                2: rb = {1'($urandom_range(0, 1)), 8'(ra[30:23] - 8'($urandom_range(0, 3))), 23'($urandom)};
                3: rb = {1'($urandom_range(0, 1)), 8'(ra[30:23] - 8'($urandom_range(20, 30))), 23'($urandom)};
                default: rb = ra;
            endcase
            op_model("rand_single", ra, rb, 1'($urandom_range(0, 1)));
        end

        // half precision instance
        sel = 1'b1;
        op_exp("half_one_plus_one", 32'h3C00, 32'h3C00, 1'b0, {4'b0000, 32'h00004000});
        op_exp("half_overflow",     32'h7BFF, 32'h7BFF, 1'b0, {4'b0101, 32'h00007C00});
        op_exp("half_inf_minus_inf", 32'h7C00, 32'h7C00, 1'b1, {4'b1000, 32'h00007E00});
        repeat (30) begin
            ra = 32'($urandom_range(0, 16'hFFFF));
            case ($urandom_range(0, 2))
                0: rb = 32'($urandom_range(0, 16'hFFFF));
                1: rb = {16'h0, 1'($urandom_range(0, 1)), ra[14:0] ^ 15'($urandom_range(0, 7))};
                default: rb = {16'h0, 1'($urandom_range(0, 1)), 5'(ra[14:10] - 5'($urandom_range(0, 14))), 10'($urandom)};
            endcase
            op_model("rand_half", ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
